dqn_episode_sequencer: RTL and testbench

Parametrised control unit for the DQN training loop. It sequences the per-step controller phases, counts steps within an episode, and closes an episode on step limit or terminal state. It counts episodes, stops training at a configurable episode budget, and supports start/pause. It drives the phase/step/episode buses consumed by the Q-network, replay and update datapath.

---
 rtl/dqn_episode_sequencer.sv | 129 ++++++++++++
 tb/tb_dqn_episode_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dqn_episode_sequencer.sv
// Step/episode sequencer for the DQN training loop: walks controller phases,
// counts steps per episode and episodes per training run, with start/pause.
module dqn_episode_sequencer #(
    parameter int PHASES         = 9,
    parameter int PHASE_W        = 4,
    parameter int MAX_STEPS      = 15,
    parameter int STEP_W         = 4,
    parameter int STATE_W        = 4,
    parameter int TERMINAL_STATE = 9,
    parameter int EPISODE_W      = 12,
    parameter int MAX_EPISODES   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    input  logic [STATE_W-1:0]   st1,
    output logic [PHASE_W-1:0]   phase,
    output logic [STEP_W-1:0]    step,
    output logic [EPISODE_W-1:0] episode,
    output logic                 step_done,
    output logic                 episode_done,
    output logic                 terminal_hit,
    output logic                 busy,
    output logic                 training_done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    localparam logic [PHASE_W-1:0]   PHASE_LAST = PHASE_W'(PHASES);
    localparam logic [STEP_W-1:0]    STEP_LAST  = STEP_W'(MAX_STEPS);
    localparam logic [STATE_W-1:0]   TERM_CODE  = STATE_W'(TERMINAL_STATE);
    localparam logic [EPISODE_W-1:0] EP_LIMIT   = EPISODE_W'(MAX_EPISODES);
    localparam bit                   BUDGETED   = (MAX_EPISODES != 0);

    state_t                 state, state_nxt;
    logic [PHASE_W-1:0]     phase_nxt;
    logic [STEP_W-1:0]      step_nxt;
    logic [EPISODE_W-1:0]   episode_nxt;
    logic [EPISODE_W-1:0]   ep_inc;
    logic                   step_done_nxt;
    logic                   episode_done_nxt;
    logic                   terminal_hit_nxt;
    logic                   wrap;
    logic                   is_terminal;

    assign wrap        = (phase == PHASE_LAST);
    assign is_terminal = (st1 == TERM_CODE);
    assign ep_inc      = episode + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            phase         <= '0;
            step          <= '0;
            episode       <= '0;
            step_done     <= 1'b0;
            episode_done  <= 1'b0;
            terminal_hit  <= 1'b0;
            busy          <= 1'b0;
            training_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            phase         <= phase_nxt;
            step          <= step_nxt;
            episode       <= episode_nxt;
            step_done     <= step_done_nxt;
            episode_done  <= episode_done_nxt;
            terminal_hit  <= terminal_hit_nxt;
            busy          <= (state_nxt == RUN) || (state_nxt == PAUSED);
            training_done <= (state_nxt == DONE);
        end
    end

    // A released pause advances immediately, so the held phase is not replayed.
    always_comb begin
        state_nxt        = state;
        phase_nxt        = phase;
        step_nxt         = step;
        episode_nxt      = episode;
        step_done_nxt    = 1'b0;
        episode_done_nxt = 1'b0;
        terminal_hit_nxt = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt   = RUN;
                    phase_nxt   = PHASE_W'(1);
                    step_nxt    = STEP_W'(1);
                    episode_nxt = '0;
                end
            end
            RUN, PAUSED: begin
                if (pause) begin
                    state_nxt = PAUSED;
                end else begin
                    state_nxt = RUN;
                    if (!wrap) begin
                        phase_nxt = phase + 1'b1;
                    end else begin
                        phase_nxt     = PHASE_W'(1);
                        step_done_nxt = 1'b1;
                        if (is_terminal || (step == STEP_LAST)) begin
                            episode_done_nxt = 1'b1;
                            terminal_hit_nxt = is_terminal;
                            step_nxt         = STEP_W'(1);
                            episode_nxt      = ep_inc;
                            if (BUDGETED && (ep_inc == EP_LIMIT)) begin
                                state_nxt = DONE;
                                phase_nxt = '0;
                                step_nxt  = '0;
                            end
                        end else begin
                            step_nxt = step + 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dqn_episode_sequencer.sv
// Randomised bench for dqn_episode_sequencer: three parameter sets driven by
// shared stimulus, each compared against its own behavioural model.
module tb_dqn_episode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic [3:0] st1;

    always #5 clk = ~clk;

    // dut0: defaults, dut1: budget of 2 episodes, dut2: 2-bit wrapping episode
    logic [3:0]  a_phase, a_step, b_phase, b_step, c_phase, c_step;
    logic [11:0] a_episode, b_episode;
    logic [1:0]  c_episode;
    logic a_sd, a_ed, a_th, a_busy, a_td;
    logic b_sd, b_ed, b_th, b_busy, b_td;
    logic c_sd, c_ed, c_th, c_busy, c_td;

    dqn_episode_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .st1(st1),
        .phase(a_phase), .step(a_step), .episode(a_episode),
        .step_done(a_sd), .episode_done(a_ed), .terminal_hit(a_th),
        .busy(a_busy), .training_done(a_td)
    );

    dqn_episode_sequencer #(.PHASES(3), .MAX_STEPS(1), .MAX_EPISODES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .st1(st1),
        .phase(b_phase), .step(b_step), .episode(b_episode),
        .step_done(b_sd), .episode_done(b_ed), .terminal_hit(b_th),
        .busy(b_busy), .training_done(b_td)
    );

    dqn_episode_sequencer #(.PHASES(2), .MAX_STEPS(1), .EPISODE_W(2), .MAX_EPISODES(0)) dut_c (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .st1(st1),
        .phase(c_phase), .step(c_step), .episode(c_episode),
        .step_done(c_sd), .episode_done(c_ed), .terminal_hit(c_th),
        .busy(c_busy), .training_done(c_td)
    );

    logic [31:0] o_phase [3];
    logic [31:0] o_step  [3];
    logic [31:0] o_ep    [3];
    logic [31:0] o_sd    [3];
    logic [31:0] o_ed    [3];
    logic [31:0] o_th    [3];
    logic [31:0] o_busy  [3];
    logic [31:0] o_td    [3];

    assign o_phase[0] = 32'(a_phase);   assign o_phase[1] = 32'(b_phase);   assign o_phase[2] = 32'(c_phase);
    assign o_step[0]  = 32'(a_step);    assign o_step[1]  = 32'(b_step);    assign o_step[2]  = 32'(c_step);
    assign o_ep[0]    = 32'(a_episode); assign o_ep[1]    = 32'(b_episode); assign o_ep[2]    = 32'(c_episode);
    assign o_sd[0]    = 32'(a_sd);      assign o_sd[1]    = 32'(b_sd);      assign o_sd[2]    = 32'(c_sd);
    assign o_ed[0]    = 32'(a_ed);      assign o_ed[1]    = 32'(b_ed);      assign o_ed[2]    = 32'(c_ed);
    assign o_th[0]    = 32'(a_th);      assign o_th[1]    = 32'(b_th);      assign o_th[2]    = 32'(c_th);
    assign o_busy[0]  = 32'(a_busy);    assign o_busy[1]  = 32'(b_busy);    assign o_busy[2]  = 32'(c_busy);
    assign o_td[0]    = 32'(a_td);      assign o_td[1]    = 32'(b_td);      assign o_td[2]    = 32'(c_td);

    int num_phases [3] = '{9, 3, 2};
    int num_steps  [3] = '{15, 1, 1};
    int ep_budget  [3] = '{0, 2, 0};
    int ep_width   [3] = '{12, 12, 2};
    localparam int TERMINAL = 9;

    typedef struct {
        bit running;
        bit finished;
        int phase;
        int step;
        int episode;
        bit sd;
        bit ed;
        bit th;
    } mdl_t;

    mdl_t m [3];

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t modelNext(mdl_t cur, int i, bit s, bit p, int st);
        mdl_t r = cur;
        r.sd = 0;
        r.ed = 0;
        r.th = 0;
        if (!cur.running) begin
            if (s) begin
                r.running  = 1;
                r.finished = 0;
                r.phase    = 1;
                r.step     = 1;
                r.episode  = 0;
            end
        end else if (!p) begin
            if (cur.phase < num_phases[i]) begin
                r.phase = cur.phase + 1;
            end else begin
                r.phase = 1;
                r.sd    = 1;
                if (st == TERMINAL || cur.step == num_steps[i]) begin
                    r.ed      = 1;
                    r.th      = (st == TERMINAL);
                    r.step    = 1;
                    r.episode = (cur.episode + 1) % (1 << ep_width[i]);
                    if (ep_budget[i] != 0 && r.episode == ep_budget[i]) begin
                        r.running  = 0;
                        r.finished = 1;
                        r.phase    = 0;
                        r.step     = 0;
                    end
                end else begin
                    r.step = cur.step + 1;
                end
            end
        end
        return r;
    endfunction

    task automatic compareAll();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("dut%0d.phase", i), o_phase[i], 32'(m[i].phase));
            checkOutput($sformatf("dut%0d.step", i), o_step[i], 32'(m[i].step));
            checkOutput($sformatf("dut%0d.episode", i), o_ep[i], 32'(m[i].episode));
            checkOutput($sformatf("dut%0d.step_done", i), o_sd[i], 32'(m[i].sd));
            checkOutput($sformatf("dut%0d.episode_done", i), o_ed[i], 32'(m[i].ed));
            checkOutput($sformatf("dut%0d.busy", i), o_busy[i], 32'(m[i].running));
            checkOutput($sformatf("dut%0d.training_done", i), o_td[i], 32'(m[i].finished));
            if (m[i].ed)
                checkOutput($sformatf("dut%0d.terminal_hit", i), o_th[i], 32'(m[i].th));
        end
    endtask

    task automatic applyStimulus(input bit s, input bit p, input logic [3:0] st);
        start = s;
        pause = p;
        st1   = st;
        @(posedge clk);
        for (int i = 0; i < 3; i++)
            m[i] = modelNext(m[i], i, s, p, int'(st));
        #1;
        compareAll();
    endtask

    task automatic clearModels();
        for (int i = 0; i < 3; i++)
            m[i] = '{default: 0};
    endtask

    // Reset is pulled between edges so the async clear is visible before the next edge.
    task automatic doReset();
        #2;
        rst = 1'b0;
        #1;
        clearModels();
        compareAll();
        @(posedge clk);
        #1;
        compareAll();
        rst = 1'b1;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        st1   = 4'd0;
        clearModels();
        repeat (2) @(posedge clk);
        #1;
        compareAll();
        rst = 1'b1;

        applyStimulus(1'b1, 1'b0, 4'd0);
        repeat (140) applyStimulus(1'b0, 1'b0, 4'd0);

        for (int k = 0; k < 200 && !(m[0].step == 3 && m[0].phase == 9); k++)
            applyStimulus(1'b0, 1'b0, (m[0].phase != 9) ? 4'd9 : 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd9);
        checkOutput("terminal_episode_end", o_ed[0], 32'd1);

        for (int k = 0; k < 200 && !(m[0].step == 2 && m[0].phase == 4); k++)
            applyStimulus(1'b0, 1'b0, 4'd0);
        repeat (5) applyStimulus(1'b0, 1'b1, 4'd0);
        repeat (5) applyStimulus(1'b0, 1'b0, 4'd0);

        for (int k = 0; k < 300 && !(m[0].step == 7 && m[0].phase == 6); k++)
            applyStimulus(1'b0, 1'b0, 4'd0);
        doReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 4'd9);

        repeat (4000) begin
            bit         s, p;
            logic [3:0] st;
            s  = ($urandom_range(0, 7) == 0);
            p  = ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 15) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0)
                doReset();
            else
                applyStimulus(s, p, st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
